// File: rtl/vm_coffee.sv
// Coffee vending controller: resource check, coin/NFC payment, one-cycle brew pulse.
// Credit saturates at 15; any excess over the price of 10 is discarded with no change given.
module vm_coffee #(
  parameter logic [1:0] S0 = 2'b00,
  parameter logic [1:0] S1 = 2'b01,
  parameter logic [1:0] S2 = 2'b10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] water,
  input  logic       beans,
  input  logic       c10,
  input  logic       c5,
  input  logic       nfc,
  output logic       coffee,
  output logic       error
);

  typedef enum logic [1:0] {
    StIdle = S0,
    StPay  = S1,
    StBrew = S2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] credit_q, credit_d;
  logic       error_q, error_d;

  logic       res_ok;
  logic [4:0] sum;
  logic [3:0] sum_sat;

  assign res_ok  = beans && (water >= 5'd2);
  assign sum     = {1'b0, credit_q} + (c10 ? 5'd10 : 5'd0) + (c5 ? 5'd5 : 5'd0);
  assign sum_sat = (sum > 5'd15) ? 4'd15 : sum[3:0];

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    error_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (res_ok) begin
          state_d = StPay;
        end else begin
          error_d = 1'b1;
        end
      end
      StPay: begin
        // Resource loss aborts the purchase even if payment arrives this cycle.
        if (!res_ok) begin
          state_d  = StIdle;
          credit_d = 4'd0;
          error_d  = 1'b1;
        end else if (nfc || (sum_sat >= 4'd10)) begin
          state_d  = StBrew;
          credit_d = 4'd0;
        end else begin
          credit_d = sum_sat;
        end
      end
      StBrew: begin
        state_d  = StIdle;
        credit_d = 4'd0;
      end
      default: begin
        state_d  = StIdle;
        credit_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      credit_q <= 4'd0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      error_q  <= error_d;
    end
  end

  assign coffee = (state_q == StBrew);
  assign error  = error_q;

endmodule

// File: tb/tb_vm_coffee.sv
// Randomized bench for vm_coffee against a purchase-level reference model.
// Directed scenarios first, then random traffic with occasional mid-cycle resets.
module tb_vm_coffee;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] water;
  logic       beans, c10, c5, nfc;
  logic       coffee, error;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: phase 0 = idle, 1 = paying, 2 = brewing
  int m_phase;
  int m_credit;
  int m_error;

  vm_coffee dut (
    .clk    (clk),
    .rst    (rst),
    .water  (water),
    .beans  (beans),
    .c10    (c10),
    .c5     (c5),
    .nfc    (nfc),
    .coffee (coffee),
    .error  (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_coffee"}, int'(coffee), (m_phase == 2) ? 1 : 0);
    check({tag, "_error"},  int'(error),  m_error);
    check({tag, "_state"},  int'(dut.state_q), m_phase);
    check({tag, "_credit"}, int'(dut.credit_q), m_credit);
  endtask

  task automatic drive(input int w, input bit b, input bit t, input bit f, input bit n);
    water = 5'(w);
    beans = b;
    c10   = t;
    c5    = f;
    nfc   = n;
  endtask

  // Advance the model by one purchase step from the current inputs.
  task automatic model_step();
    bit ok;
    int paid;
    ok = (beans == 1'b1) && (int'(water) >= 2);
    m_error = 0;
    if (m_phase == 0) begin
      if (ok) m_phase = 1;
      else    m_error = 1;
    end else if (m_phase == 1) begin
      if (!ok) begin
        m_phase = 0; m_credit = 0; m_error = 1;
      end else if (nfc) begin
        m_phase = 2; m_credit = 0;
      end else begin
        paid = m_credit + (c10 ? 10 : 0) + (c5 ? 5 : 0);
        if (paid > 15) paid = 15;
        if (paid >= 10) begin
          m_phase = 2; m_credit = 0;
        end else begin
          m_credit = paid;
        end
      end
    end else begin
      m_phase = 0; m_credit = 0;
    end
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Called at posedge+1: pulse reset between edges and check its immediate effect.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    m_phase = 0; m_credit = 0; m_error = 0;
    check_all(tag);
    #1 rst = 1'b0;
  endtask

  initial begin
    m_phase = 0; m_credit = 0; m_error = 0;
    drive(31, 1, 0, 0, 0);
    rst = 1'b1;
    #1;
    check_all("reset");
    #3 rst = 1'b0;

    // Resource check: low water flags error, recovery enters pay
    drive(1, 1, 0, 0, 0);
    tick("low_water");
    check("low_water_err_direct", int'(error), 1);
    drive(2, 1, 0, 0, 0);
    tick("water_ok");
    check("water_ok_err_direct", int'(error), 0);

    // Two 5-coins then brew pulse
    drive(20, 1, 0, 1, 0);
    tick("c5_first");
    check("c5_first_credit_direct", int'(dut.credit_q), 5);
    tick("c5_second");
    check("c5_second_coffee_direct", int'(coffee), 1);
    drive(20, 1, 0, 0, 0);
    tick("brew_done");
    tick("to_pay");

    // Simultaneous coins: 15 saturates, excess lost
    drive(20, 1, 1, 1, 0);
    tick("both_coins");
    drive(20, 1, 0, 0, 0);
    tick("both_done");
    tick("to_pay2");

    // NFC wins over coins
    drive(20, 1, 0, 1, 0);
    tick("nfc_pre");
    drive(20, 1, 1, 0, 1);
    tick("nfc_pay");
    drive(20, 1, 0, 0, 0);
    tick("nfc_done");
    tick("to_pay3");

    // Beans lost mid-payment
    drive(20, 1, 0, 1, 0);
    tick("loss_pre");
    drive(20, 0, 0, 0, 0);
    tick("beans_lost");
    check("beans_lost_err_direct", int'(error), 1);
    drive(20, 1, 0, 0, 0);
    tick("recover");

    // Reset during brew kills the pulse immediately
    drive(20, 1, 1, 0, 0);
    tick("brew_for_rst");
    async_reset("rst_in_brew");
    check("rst_in_brew_coffee_direct", int'(coffee), 0);
    drive(20, 1, 0, 0, 0);
    tick("post_rst");

    for (int i = 0; i < 500; i++) begin
      drive(($urandom_range(0, 9) == 0) ? $urandom_range(0, 1) : $urandom_range(0, 31),
            $urandom_range(0, 9) != 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) == 0);
      tick("rand");
      if ($urandom_range(0, 49) == 0) async_reset("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
